// File: rtl/htv_absum_stream.sv
// htv_absum_stream: collects a block of 4 or 8 horizontally-transformed rows,
// applies a vertical Sylvester Hadamard transform per column and reports the
// sum of absolute transformed coefficients over the whole block.
module htv_absum_stream #(
  parameter int LENGTH = 11,
  parameter int COLS   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COLS*(LENGTH+1)-1:0]    in_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LENGTH+9:0]             sum_out
);

  localparam int CW = LENGTH + 1;   // coefficient width
  localparam int VW = LENGTH + 4;   // vertical stage width
  localparam int AW = LENGTH + 10;  // abs / accumulate width

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]           state;
  logic [2:0]           row_cnt;
  logic                 mode;
  logic [COLS*CW-1:0]   rowbuf [8];
  logic                 accept;
  logic                 cur_mode;
  logic                 last_row;
  logic [AW-1:0]        calc_sum;

  assign in_ready = (state == FILL);
  assign accept   = (state == FILL) && in_valid && !abort;
  // Row 0 takes the block height straight from sel; later rows use the sample.
  assign cur_mode = (row_cnt == 3'd0) ? sel : mode;
  assign last_row = cur_mode ? (row_cnt == 3'd7) : (row_cnt == 3'd3);

  // Row buffer: written on acceptance only, never cleared.
  always_ff @(posedge clk) begin
    if (accept) rowbuf[row_cnt] <= in_row;
  end

  // Vertical Hadamard per column, absolute values summed over the block.
  // Output k uses sign (-1)^popcount(k & i) for row i; rows beyond the block
  // height are masked, and in 4-row mode outputs 4..7 duplicate 0..3 so they
  // are skipped.
  always_comb begin
    logic signed [VW-1:0] acc;
    logic        [CW-1:0] x;
    logic signed [AW-1:0] ye;
    logic        [2:0]    ki;
    calc_sum = '0;
    acc      = '0;
    x        = '0;
    ye       = '0;
    ki       = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
          x  = rowbuf[i][c*CW +: CW];
          ki = 3'(k) & 3'(i);
          if (mode || (i < 4)) begin
            if (^ki) acc = acc - signed'({{3{x[CW-1]}}, x});
            else     acc = acc + signed'({{3{x[CW-1]}}, x});
          end
        end
        ye = signed'({{6{acc[VW-1]}}, acc});
        if (mode || (k < 4)) begin
          calc_sum = calc_sum + unsigned'(ye[AW-1] ? -ye : ye);
        end
      end
    end
  end

  // Control FSM, sampled mode and result register.
  // out_valid rises one cycle after HOLD entry, giving a two-edge latency
  // from the last accepted row; abort is only honoured while filling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      row_cnt   <= '0;
      mode      <= 1'b0;
      out_valid <= 1'b0;
      sum_out   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (abort) begin
            row_cnt <= '0;
          end else if (in_valid) begin
            if (row_cnt == 3'd0) mode <= sel;
            if (last_row) begin
              state   <= CALC;
              row_cnt <= '0;
            end else begin
              row_cnt <= row_cnt + 3'd1;
            end
          end
        end
        CALC: begin
          sum_out <= calc_sum;
          state   <= HOLD;
        end
        HOLD: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/htv_absum_stream.md
HTV_ABSUM_STREAM -- requirements
Module: htv_absum_stream

Interface
REQ-001 SHALL have parameter LENGTH, default 11: MSB index of each signed input coefficient, so each coefficient is LENGTH+1 bits.
REQ-002 SHALL have parameter COLS, default 8: coefficients per row; legal values 4 and 8.
REQ-003 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sel  input  1  block height: 0 = 4 rows (4-point vertical Hadamard), 1 = 8 rows (8-point).
REQ-007 abort  input  1  synchronous discard of the block in progress.
REQ-008 in_valid  input  1  in_row carries a valid horizontally-transformed row.
REQ-009 in_ready  output  1  block can accept a row this cycle.
REQ-010 in_row  input  COLS*(LENGTH+1)  packed signed coefficients; lane c occupies bits [c*(LENGTH+1) +: LENGTH+1].
REQ-011 out_valid  output  1  sum_out holds a completed block result.
REQ-012 out_ready  input  1  consumer accepts sum_out.
REQ-013 sum_out  output  LENGTH+10  unsigned sum of absolute vertical-Hadamard coefficients of one block.

Function
REQ-014 SHALL run a 3-state FSM: FILL, CALC, HOLD.
REQ-015 In FILL, in_ready SHALL be 1; in CALC and HOLD, in_ready SHALL be 0.
REQ-016 A row SHALL be accepted on a rising edge where in_valid and in_ready are both 1, and SHALL be written to row buffer entry row_cnt.
REQ-017 sel SHALL be sampled only on acceptance of row 0; the sampled value sets N (4 or 8) for the whole block, and later sel changes SHALL have no effect on it.
REQ-018 row_cnt (3 bits) SHALL increment on each accepted row; on acceptance of row N-1, the FSM SHALL go to CALC and row_cnt SHALL return to 0.
REQ-019 CALC (exactly 1 cycle) SHALL compute, for each column c, y = H_N * x_c over rows 0..N-1, where H_N is the Sylvester Hadamard matrix with unnormalised entries ±1.
REQ-020 CALC SHALL register the sum over all columns and all N outputs of |y| into sum_out, then move to HOLD.
REQ-021 Coefficient ordering within y SHALL be free, because the sum is order-invariant.
REQ-022 Arithmetic SHALL be full precision with no saturation or truncation.
REQ-023 Width rules: vertical stage width is LENGTH+4 signed; abs and accumulate width is LENGTH+10 unsigned.
REQ-024 |(-2^(LENGTH+3))| SHALL be represented exactly in the unsigned domain.
REQ-025 Latency: if the last row is accepted at edge k, out_valid SHALL be 1 after edge k+2.
REQ-026 In HOLD, out_valid SHALL be 1, and sum_out SHALL be stable until an edge with out_ready=1.
REQ-027 On that edge the FSM SHALL return to FILL, so in_ready=1 on the following cycle.
REQ-028 Rows offered during CALC or HOLD SHALL NOT be accepted; the source holds them.
REQ-029 abort=1 in FILL SHALL clear row_cnt and discard buffered rows; any row offered on the same edge SHALL be dropped, and abort has priority.
REQ-030 abort=1 in CALC or HOLD SHALL be ignored; a completed result is never lost.
REQ-031 The row buffer SHALL NOT need clearing between blocks, since only rows 0..N-1 of the current block are used.
REQ-032 In 4-row mode, buffer rows 4..7 SHALL be don't-care and SHALL NOT affect sum_out.

Reset
REQ-033 rst_n=0 SHALL immediately force: state=FILL, row_cnt=0, sampled mode=0, in_ready=1, out_valid=0, sum_out=0.
REQ-034 Row buffer contents need not be reset.
REQ-035 Reset asserted mid-block or during HOLD SHALL abandon the block; no partial result SHALL appear after release.
REQ-036 After rst_n deasserts, the first accepted row SHALL be treated as row 0.

Verification
REQ-037 COLS=8, sel=1, row 0 lane 0 = 5, all other coefficients 0 -> sum_out=40, out_valid 2 edges after row 7 accepted.
REQ-038 COLS=8, sel=0, all coefficients = 1 for 4 rows -> each column y = {4,0,0,0} -> sum_out=32.
REQ-039 LENGTH=11, sel=1, all coefficients = -2048 -> sum_out = 64*2048 = 131072; no overflow.
REQ-040 Back-to-back blocks with out_ready=0 for 5 cycles -> in_ready=0 and sum_out stable throughout; next block accepted the cycle after the out_ready edge.
REQ-041 abort after 3 rows, then 8 fresh rows -> result matches the fresh rows only; abort during HOLD leaves out_valid=1 unchanged.
REQ-042 sel toggled after row 0 of an 8-row block -> block still completes after 8 rows with the 8-point result; rst_n pulsed at row 5 -> out_valid=0 and the next block starts at row 0.
